// File: rtl/seq_pkg.sv
// Shared types for the opcode sequencer: instruction word layout,
// instruction type codes and controller state encoding.
package seq_pkg;

    localparam int WORD_W    = 18;
    localparam int PAYLOAD_W = 16;
    localparam int CNT_HI    = 15;
    localparam int CNT_LO    = 8;
    localparam int SYNC_BIT  = 0;

    typedef enum logic [1:0] {
        TYPE_EXEC = 2'b00,
        TYPE_JUMP = 2'b01,
        TYPE_WAIT = 2'b10,
        TYPE_LOOP = 2'b11
    } instr_type_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_FETCH  = 2'b01,
        S_DECODE = 2'b10,
        S_WAIT   = 2'b11
    } state_t;

    typedef struct packed {
        instr_type_t          kind;
        logic [PAYLOAD_W-1:0] payload;
    } instr_t;

endpackage

// File: rtl/prog_mem.sv
// Program store: DEPTH x WORD_W register file, one write port and a
// registered read port that holds its value while re is low.
module prog_mem
    import seq_pkg::*;
#(
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/opcode_sequencer.sv
// Programmable opcode sequencer feeding the GPU core array: walks a
// small program with jumps, one counted loop level and sync stalls.
module opcode_sequencer
    import seq_pkg::*;
#(
    parameter  int PROG_DEPTH = 64,
    localparam int ADDR_W     = $clog2(PROG_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [WORD_W-1:0] prog_data,
    input  logic              line_start,
    input  logic              frame_start,
    output logic [15:0]       opcode,
    output logic              execute,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              waiting
);

    state_t            state;
    logic [7:0]        loop_cnt;
    logic              loop_armed;
    logic [WORD_W-1:0] rdata;
    instr_t            ir;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_inc;
    logic [7:0]        count;
    logic              sync_hit;

    assign ir       = instr_t'(rdata);
    assign target   = ir.payload[ADDR_W-1:0];
    assign pc_inc   = pc + 1'b1;
    assign count    = ir.payload[CNT_HI:CNT_LO];
    assign sync_hit = ir.payload[SYNC_BIT] ? frame_start : line_start;
    assign busy     = (state != S_IDLE);
    assign waiting  = (state == S_WAIT);

    prog_mem #(.DEPTH(PROG_DEPTH)) u_mem (
        .clk   (clk),
        .we    (prog_we && state == S_IDLE),
        .waddr (prog_addr),
        .wdata (prog_data),
        .re    (state == S_FETCH),
        .raddr (pc),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc         <= '0;
            opcode     <= '0;
            execute    <= 1'b0;
            loop_cnt   <= '0;
            loop_armed <= 1'b0;
        end else begin
            execute <= 1'b0;
            // Dropping run aborts from any state, suppressing a pending issue
            if (state != S_IDLE && !run) begin
                state <= S_IDLE;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (run) begin
                            pc         <= '0;
                            loop_armed <= 1'b0;
                            state      <= S_FETCH;
                        end
                    end
                    S_FETCH: state <= S_DECODE;
                    S_DECODE: begin
                        state <= S_FETCH;
                        unique case (ir.kind)
                            TYPE_EXEC: begin
                                opcode  <= ir.payload;
                                execute <= 1'b1;
                                pc      <= pc_inc;
                            end
                            TYPE_JUMP: pc <= target;
                            TYPE_WAIT: state <= S_WAIT;
                            TYPE_LOOP: begin
                                if (!loop_armed) begin
                                    if (count == '0) begin
                                        pc <= pc_inc;
                                    end else begin
                                        loop_cnt   <= count;
                                        loop_armed <= 1'b1;
                                        pc         <= target;
                                    end
                                end else if (loop_cnt == 8'd1) begin
                                    loop_armed <= 1'b0;
                                    pc         <= pc_inc;
                                end else begin
                                    loop_cnt <= loop_cnt - 8'd1;
                                    pc       <= target;
                                end
                            end
                        endcase
                    end
                    S_WAIT: begin
                        if (sync_hit) begin
                            pc    <= pc_inc;
                            state <= S_FETCH;
                        end
                    end
                endcase
            end
        end
    end

endmodule
